// File: rtl/reshuffle_pkg.sv
`default_nettype none
// ============================================================================
// Module   : reshuffle_pkg
// Brief    : Shared state encoding, step type and modular step helper for the
//            reshuffle tile scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package reshuffle_pkg;

    localparam int unsigned c_N  = 4;
    localparam int unsigned c_SW = $clog2(c_N);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } rsh_state_e;

    typedef logic [c_SW-1:0] step_t;

    // inc is always < n, so a single conditional subtract is enough to wrap
    function automatic int unsigned step_add(input int unsigned step,
                                             input int unsigned inc,
                                             input int unsigned n = c_N);
        int unsigned sum;
        sum = step + inc;
        return (sum >= n) ? (sum - n) : sum;
    endfunction

endpackage
`default_nettype wire

// File: rtl/reshuffle_network.sv
`default_nettype none
// ============================================================================
// Module   : reshuffle_network
// Brief    : Combinational row rotation of an NxN tile:
//            out[r][c] = in[(r+step) mod N][c].
// Revision : 1.0 - initial release
// ============================================================================
module reshuffle_network #(
    parameter  int N     = 4,
    parameter  int WIDTH = 32,
    localparam int SW    = $clog2(N)
) (
    input  logic [SW-1:0]             step,
    input  logic signed [WIDTH-1:0]   in_patch  [N][N],
    output logic signed [WIDTH-1:0]   out_patch [N][N]
);

    for (genvar gr = 0; gr < N; gr++) begin : g_row
        logic [SW:0]   w_sum;
        logic [SW-1:0] w_src;

        assign w_sum = (SW+1)'(gr) + {1'b0, step};
        assign w_src = (w_sum >= (SW+1)'(N)) ? SW'(w_sum - (SW+1)'(N)) : SW'(w_sum);

        for (genvar gc = 0; gc < N; gc++) begin : g_col
            assign out_patch[gr][gc] = in_patch[w_src][gc];
        end
    end

endmodule
`default_nettype wire

// File: rtl/rsh_tile_counter.sv
`default_nettype none
// ============================================================================
// Module   : rsh_tile_counter
// Brief    : Column/row/step counters for the tile stream plus last-tile
//            detection against the latched frame geometry.
// Revision : 1.0 - initial release
// ============================================================================
module rsh_tile_counter
    import reshuffle_pkg::*;
#(
    parameter  int N     = 4,
    parameter  int DIM_W = 12,
    localparam int SW    = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             advance,
    input  logic [DIM_W-1:0] tiles_per_row,
    input  logic [DIM_W-1:0] rows,
    input  logic [SW-1:0]    step_inc,
    output logic [SW-1:0]    step,
    output logic [DIM_W-1:0] col,
    output logic [DIM_W-1:0] row,
    output logic             last
);

    logic [SW-1:0]    r_step;
    logic [DIM_W-1:0] r_col;
    logic [DIM_W-1:0] r_row;
    logic             w_col_end;

    assign w_col_end = (r_col == tiles_per_row - 1'b1);
    assign last      = w_col_end && (r_row == rows - 1'b1);
    assign step      = r_step;
    assign col       = r_col;
    assign row       = r_row;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_step <= '0;
            r_col  <= '0;
            r_row  <= '0;
        end else if (advance) begin
            if (w_col_end) begin
                // every new row restarts the rotation sequence
                r_col  <= '0;
                r_row  <= r_row + 1'b1;
                r_step <= '0;
            end else begin
                r_col  <= r_col + 1'b1;
                r_step <= SW'(step_add(32'(r_step), 32'(step_inc), N));
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/reshuffle_tile_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : reshuffle_tile_scheduler
// Brief    : Accepts NxN tiles from the PosT array, rotates rows by a per-tile
//            step and registers the result toward the output buffer with tile
//            coordinates and a last flag. RESHUFFLE_BYPASS_EN adds cfg_bypass.
// Revision : 1.0 - initial release
// ============================================================================
module reshuffle_tile_scheduler
    import reshuffle_pkg::*;
#(
    parameter  int N     = 4,
    parameter  int WIDTH = 32,
    parameter  int DIM_W = 12,
    localparam int SW    = $clog2(N)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [DIM_W-1:0]        cfg_tiles_per_row,
    input  logic [DIM_W-1:0]        cfg_rows,
    input  logic [SW-1:0]           cfg_step_inc,
`ifdef RESHUFFLE_BYPASS_EN
    input  logic                    cfg_bypass,
`endif
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] in_patch  [N][N],
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH-1:0] out_patch [N][N],
    output logic [SW-1:0]           out_step,
    output logic [DIM_W-1:0]        out_col,
    output logic [DIM_W-1:0]        out_row,
    output logic                    out_last,
    output logic                    busy,
    output logic                    done
);

    rsh_state_e r_state;
    rsh_state_e w_next;

    logic [DIM_W-1:0] r_tpr;
    logic [DIM_W-1:0] r_rows;
    logic [SW-1:0]    r_inc;
    logic             w_start_ok;
    logic             w_can_take;
    logic             w_accept;
    logic [SW-1:0]    w_step;
    logic [SW-1:0]    w_net_step;
    logic [DIM_W-1:0] w_col;
    logic [DIM_W-1:0] w_row;
    logic             w_last;
    logic signed [WIDTH-1:0] w_perm [N][N];

    assign w_start_ok = start && (r_state == IDLE);
    assign w_can_take = (r_state == RUN) && (!out_valid || out_ready);
    assign w_accept   = in_valid && w_can_take;
    assign in_ready   = w_can_take;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tpr  <= '0;
            r_rows <= '0;
            r_inc  <= '0;
        end else if (w_start_ok) begin
            r_tpr  <= cfg_tiles_per_row;
            r_rows <= cfg_rows;
            r_inc  <= cfg_step_inc;
        end
    end

`ifdef RESHUFFLE_BYPASS_EN
    logic r_bypass;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bypass <= 1'b0;
        end else if (w_start_ok) begin
            r_bypass <= cfg_bypass;
        end
    end

    // counters keep running in bypass; only the applied rotation is zeroed
    assign w_net_step = r_bypass ? '0 : w_step;
`else
    assign w_net_step = w_step;
`endif

    rsh_tile_counter #(
        .N     (N),
        .DIM_W (DIM_W)
    ) u_counter (
        .clk           (clk),
        .rst           (rst),
        .clear         (w_start_ok),
        .advance       (w_accept),
        .tiles_per_row (r_tpr),
        .rows          (r_rows),
        .step_inc      (r_inc),
        .step          (w_step),
        .col           (w_col),
        .row           (w_row),
        .last          (w_last)
    );

    reshuffle_network #(
        .N     (N),
        .WIDTH (WIDTH)
    ) u_network (
        .step      (w_net_step),
        .in_patch  (in_patch),
        .out_patch (w_perm)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        busy   = 1'b1;
        done   = 1'b0;
        case (r_state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_next = ((cfg_tiles_per_row == '0) || (cfg_rows == '0)) ? DONE : RUN;
                end
            end
            RUN: begin
                if (w_accept && w_last) begin
                    w_next = DRAIN;
                end
            end
            DRAIN: begin
                if (out_valid && out_ready) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                done   = 1'b1;
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_step  <= '0;
            out_col   <= '0;
            out_row   <= '0;
            out_last  <= 1'b0;
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    out_patch[r][c] <= '0;
                end
            end
        end else if (w_accept) begin
            out_valid <= 1'b1;
            out_step  <= w_net_step;
            out_col   <= w_col;
            out_row   <= w_row;
            out_last  <= w_last;
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    out_patch[r][c] <= w_perm[r][c];
                end
            end
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire
